// File: rtl/process1_monitor_pkg.sv
// process1_monitor_pkg: shared widths and controller state encoding for the
// process monitor 1 sequencer.
package process1_monitor_pkg;
   localparam int PR1_NB_MONITOR = 14;
   localparam int PR1_COUNT_W = 16;
   localparam int PR1_TARGET_W = 4;
   localparam int PR1_CTRL_TIMEOUT_CYCLES = 1048576;
   localparam int PR1_CTRL_TMO_W = $clog2(PR1_CTRL_TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_RUN, S_CAPTURE, S_HOLD, S_DRAIN, S_DONE
   } pr1_ctrl_state_e;
endpackage

// File: rtl/process1_monitor_ctrl_if.sv
// process1_monitor_ctrl_if: CSR-side request/result and monitor-side signals;
// master is the sequencer, slave is the CSR block plus monitor.
interface process1_monitor_ctrl_if
   import process1_monitor_pkg::*;
#(
   parameter int SAMPLE_W = 4
);
   localparam int SUM_W = PR1_COUNT_W + SAMPLE_W;
   logic                                start;
   logic                                abort;
   logic [PR1_TARGET_W-1:0]             target;
   logic [PR1_NB_MONITOR-1:0]           use_ro;
   logic [SAMPLE_W-1:0]                 num_samples;
   logic                                busy;
   logic                                done;
   logic                                err_timeout;
   logic                                res_valid;
   logic [PR1_NB_MONITOR*SUM_W-1:0]     res_count;
   logic                                pm_enable;
   logic [PR1_TARGET_W-1:0]             pm_target;
   logic [PR1_NB_MONITOR-1:0]           pm_use_ro;
   logic                                pm_valid;
   logic [PR1_NB_MONITOR*PR1_COUNT_W-1:0] pm_count;
   modport master (
      input  start, abort, target, use_ro, num_samples, pm_valid, pm_count,
      output busy, done, err_timeout, res_valid, res_count, pm_enable, pm_target, pm_use_ro
   );
   modport slave (
      output start, abort, target, use_ro, num_samples, pm_valid, pm_count,
      input  busy, done, err_timeout, res_valid, res_count, pm_enable, pm_target, pm_use_ro
   );
endinterface

// File: rtl/pr1_count_accum.sv
// pr1_count_accum: running sum for one oscillator; clear wins over add, and
// add only takes effect when the oscillator is selected.
module pr1_count_accum #(
   parameter int COUNT_W = 16,
   parameter int SUM_W = 20
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               add_i,
   input  logic               use_i,
   input  logic [COUNT_W-1:0] count_i,
   output logic [SUM_W-1:0]   sum_o
);
   logic [SUM_W-1:0] sum_q, sum_d;
   always_comb sum_d = clr_i ? '0 : (add_i && use_i) ? sum_q + SUM_W'(count_i) : sum_q;
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) sum_q <= '0;
      else sum_q <= sum_d;
   assign sum_o = sum_q;
endmodule

// File: rtl/process1_monitor_ctrl.sv
// process1_monitor_ctrl: runs the monitor enable/valid cycle num_samples times,
// sums per-oscillator counts and publishes them on success.
module process1_monitor_ctrl
   import process1_monitor_pkg::*;
#(
   parameter int SAMPLE_W = 4,
   parameter int SETUP_CYCLES = 4,
   parameter int HOLD_CYCLES = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input logic clock,
   input logic rst_n,
   process1_monitor_ctrl_if.master bus
);
   localparam int SUM_W = PR1_COUNT_W + SAMPLE_W;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   pr1_ctrl_state_e                 state_q, state_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic [SAMPLE_W-1:0]             nsmp_q, nsmp_d, smp_q, smp_d;
   logic                            busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                            rv_q, rv_d, en_q, en_d;
   logic [PR1_TARGET_W-1:0]         tgt_q, tgt_d;
   logic [PR1_NB_MONITOR-1:0]       use_q, use_d;
   logic [PR1_NB_MONITOR*SUM_W-1:0] res_q, res_d, acc;
   logic                            accept;
   assign accept = (state_q == S_IDLE) && bus.start;
   always_comb begin
      state_d = state_q;
      nsmp_d = nsmp_q;
      smp_d = smp_q;
      err_d = err_q;
      rv_d = rv_q;
      tgt_d = tgt_q;
      use_d = use_q;
      res_d = res_q;
      case (state_q)
         S_IDLE:
            if (bus.start) begin
               state_d = S_SETUP;
               tgt_d = bus.target;
               use_d = bus.use_ro;
               nsmp_d = (bus.num_samples == '0) ? SAMPLE_W'(1) : bus.num_samples;
               smp_d = '0;
               err_d = 1'b0;
               rv_d = 1'b0;
            end
         S_SETUP: state_d = bus.abort ? S_DRAIN : (cnt_q == CW'(SETUP_CYCLES - 1)) ? S_RUN : S_SETUP;
         S_RUN:
            // abort beats a coincident valid; valid beats a coincident timeout
            if (bus.abort) state_d = S_DRAIN;
            else if (bus.pm_valid) state_d = S_CAPTURE;
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_DRAIN;
               err_d = 1'b1;
            end
         S_CAPTURE: begin
            state_d = bus.abort ? S_DRAIN : S_HOLD;
            smp_d = smp_q + 1'b1;
         end
         S_HOLD:
            if (bus.abort) state_d = S_DRAIN;
            else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               state_d = (smp_q == nsmp_q) ? S_DONE : S_RUN;
               res_d = (smp_q == nsmp_q) ? acc : res_q;
               rv_d = rv_q | (smp_q == nsmp_q);
            end
         S_DRAIN: state_d = (cnt_q == CW'(HOLD_CYCLES - 1)) ? S_DONE : S_DRAIN;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
      busy_d = state_d inside {S_SETUP, S_RUN, S_CAPTURE, S_HOLD, S_DRAIN};
      done_d = state_d == S_DONE;
      en_d = state_d inside {S_RUN, S_CAPTURE};
   end
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         nsmp_q <= '0;
         smp_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         rv_q <= 1'b0;
         en_q <= 1'b0;
         tgt_q <= '0;
         use_q <= '0;
         res_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         nsmp_q <= nsmp_d;
         smp_q <= smp_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
         rv_q <= rv_d;
         en_q <= en_d;
         tgt_q <= tgt_d;
         use_q <= use_d;
         res_q <= res_d;
      end
   for (genvar i = 0; i < PR1_NB_MONITOR; i++) begin : g_acc
      pr1_count_accum #(.COUNT_W(PR1_COUNT_W), .SUM_W(SUM_W)) u_acc (
         .clock(clock),
         .rst_n(rst_n),
         .clr_i(accept),
         .add_i(state_q == S_CAPTURE),
         .use_i(use_q[i]),
         .count_i(bus.pm_count[i*PR1_COUNT_W +: PR1_COUNT_W]),
         .sum_o(acc[i*SUM_W +: SUM_W])
      );
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err_timeout = err_q;
   assign bus.res_valid = rv_q;
   assign bus.res_count = res_q;
   assign bus.pm_enable = en_q;
   assign bus.pm_target = tgt_q;
   assign bus.pm_use_ro = use_q;
endmodule

// File: tb/tb_process1_monitor_ctrl.sv
// tb_process1_monitor_ctrl: randomized runs against a timeline/sum model of the
// sequencer, with a delay-programmable monitor stand-in.
module tb_process1_monitor_ctrl;
   import process1_monitor_pkg::*;
   localparam int SW = 4, SC = 4, HC = 4, TC = 64;
   localparam int SUM_W = PR1_COUNT_W + SW, RW = PR1_NB_MONITOR * SUM_W;
   logic clock = 1'b0, rst_n = 1'b0;
   int total = 0, bad = 0, cyc = 0;
   process1_monitor_ctrl_if #(.SAMPLE_W(SW)) bus ();
   process1_monitor_ctrl #(.SAMPLE_W(SW), .SETUP_CYCLES(SC), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TC)) dut (
      .clock(clock), .rst_n(rst_n), .bus(bus)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   // per-run stimulus and model state
   logic [15:0] tbl [16][14];
   int dly [16];
   bit abt_first = 0, active = 0;
   bit e_en [2048];
   bit e_busy [2048];
   int done_off = 0, err_off = 0, st = 0, en_hi = 0;
   bit succ = 0, prev_rv = 0, prev_err = 0;
   logic [RW-1:0] new_res = '0, prev_res = '0, keep;
   logic [PR1_TARGET_W-1:0] c_tgt, prev_tgt = '0;
   logic [13:0] c_use, prev_use = '0;
   logic [SW-1:0] c_num;
   task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
      end
   endtask
   function automatic logic [319:0] outs();
      return {bus.busy, bus.done, bus.err_timeout, bus.res_valid, bus.res_count,
              bus.pm_enable, bus.pm_target, bus.pm_use_ro};
   endfunction
   // monitor stand-in: valid rises dly[k] cycles after enable rises; dly<0 never
   initial begin
      int ecnt, midx;
      ecnt = 0;
      midx = 0;
      bus.pm_valid = 1'b0;
      bus.pm_count = '0;
      bus.abort = 1'b0;
      forever begin
         @(negedge clock);
         bus.abort = 1'b0;
         if (!bus.busy) midx = 0;
         if (bus.pm_enable !== 1'b1) begin
            ecnt = 0;
            bus.pm_valid = 1'b0;
         end else begin
            ecnt++;
            if (!bus.pm_valid && midx < 16 && dly[midx] >= 0 && ecnt == dly[midx] + 1) begin
               bus.pm_valid = 1'b1;
               for (int i = 0; i < 14; i++) bus.pm_count[i*16 +: 16] = tbl[midx][i];
               if (abt_first && midx == 0) bus.abort = 1'b1;
               midx++;
            end
         end
      end
   end
   // cycle-by-cycle comparison against the run timeline
   initial forever begin
      @(negedge clock);
      if (active) begin
         int off;
         off = cyc - st;
         if (off >= 0 && off <= done_off + 2) begin
            if (off <= 1) en_hi = 0;
            if (bus.pm_enable === 1'b1) en_hi++;
            chk("busy", bus.busy, e_busy[off]);
            chk("done", bus.done, off == done_off);
            chk("pm_enable", bus.pm_enable, e_en[off]);
            chk("res_valid", bus.res_valid, off == 0 ? prev_rv : (off >= done_off && succ));
            chk("err_timeout", bus.err_timeout, off == 0 ? prev_err : off >= err_off);
            chk("res_count", bus.res_count, (off >= done_off && succ) ? new_res : prev_res);
            chk("pm_target", bus.pm_target, off == 0 ? prev_tgt : c_tgt);
            chk("pm_use_ro", bus.pm_use_ro, off == 0 ? prev_use : c_use);
         end
      end
   end
   task automatic do_run(input bit poke, input bit abt);
      int n, t, v;
      abt_first = abt;
      n = (c_num == 0) ? 1 : int'(c_num);
      for (int j = 0; j < 2048; j++) begin
         e_en[j] = 0;
         e_busy[j] = 0;
      end
      t = 1 + SC;
      succ = 1;
      err_off = 1 << 30;
      new_res = '0;
      for (int k = 0; k < n; k++) begin
         if (dly[k] < 0) begin
            for (int j = t; j < t + TC; j++) e_en[j] = 1;
            err_off = t + TC;
            t = t + TC + HC;
            succ = 0;
            break;
         end
         v = t + dly[k];
         if (abt && k == 0) begin
            for (int j = t; j <= v; j++) e_en[j] = 1;
            t = v + 1 + HC;
            succ = 0;
            break;
         end
         for (int j = t; j <= v + 1; j++) e_en[j] = 1;
         for (int i = 0; i < 14; i++)
            if (c_use[i]) new_res[i*SUM_W +: SUM_W] = new_res[i*SUM_W +: SUM_W] + SUM_W'(tbl[k][i]);
         t = v + 2 + HC;
      end
      done_off = t;
      for (int j = 1; j < t; j++) e_busy[j] = 1;
      bus.target = c_tgt;
      bus.use_ro = c_use;
      bus.num_samples = c_num;
      bus.start = 1'b1;
      st = cyc;
      active = 1;
      for (int o = 1; o <= done_off + 3; o++) begin
         @(negedge clock);
         // extra starts while busy and on the done cycle must be ignored
         bus.start = poke && (o == 3 || o == done_off);
         if (poke && o == 3) bus.target = ~c_tgt;
      end
      active = 0;
      if (succ) prev_res = new_res;
      prev_rv = succ;
      prev_err = err_off < (1 << 30);
      prev_tgt = c_tgt;
      prev_use = c_use;
   endtask
   task automatic fill(input int lo, input int hi);
      for (int k = 0; k < 16; k++) begin
         dly[k] = $urandom_range(hi, lo);
         for (int i = 0; i < 14; i++) tbl[k][i] = 16'($urandom);
      end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.target = '0;
      bus.use_ro = '0;
      bus.num_samples = '0;
      fill(0, 10);
      repeat (3) @(negedge clock);
      chk("reset_outputs", outs(), '0);
      rst_n = 1'b1;
      @(negedge clock);
      chk("post_reset_outputs", outs(), '0);
      // all 100, single sample via num_samples=0
      c_tgt = 4'd3; c_use = 14'h3FFF; c_num = 0;
      for (int k = 0; k < 16; k++) for (int i = 0; i < 14; i++) tbl[k][i] = 16'd100;
      do_run(0, 0);
      for (int i = 0; i < 14; i++) begin
         chk("t1_slice", bus.res_count[i*SUM_W +: SUM_W], 100);
         chk("t1_model", new_res[i*SUM_W +: SUM_W], 100);
      end
      chk("t1_valid", bus.res_valid, 1);
      chk("t1_err", bus.err_timeout, 0);
      // three samples, oscillators 0 and 2 selected
      fill(0, 8);
      for (int k = 0; k < 16; k++) begin
         tbl[k][0] = 16'd1000; tbl[k][1] = 16'd2000; tbl[k][2] = 16'd3000;
      end
      c_tgt = 4'd9; c_use = 14'h0005; c_num = 3;
      do_run(0, 0);
      chk("t2_slice0", bus.res_count[0*SUM_W +: SUM_W], 3000);
      chk("t2_slice1", bus.res_count[1*SUM_W +: SUM_W], 0);
      chk("t2_slice2", bus.res_count[2*SUM_W +: SUM_W], 9000);
      chk("t2_model2", new_res[2*SUM_W +: SUM_W], 9000);
      // fifteen full-scale samples must not overflow
      fill(0, 3);
      for (int k = 0; k < 16; k++) for (int i = 0; i < 14; i++) tbl[k][i] = 16'hFFFF;
      c_tgt = 4'hF; c_use = 14'h3FFF; c_num = 15;
      do_run(1, 0);
      for (int i = 0; i < 14; i++) chk("t3_slice", bus.res_count[i*SUM_W +: SUM_W], 20'hEFFF1);
      // randomized runs
      for (int r = 0; r < 6; r++) begin
         fill(0, 12);
         c_tgt = 4'($urandom); c_use = 14'($urandom); c_num = 4'($urandom);
         do_run(1'($urandom), 0);
      end
      // timeout: monitor never answers
      fill(0, 5);
      dly[0] = -1;
      keep = bus.res_count;
      c_tgt = 4'd6; c_use = 14'h1234; c_num = 2;
      do_run(0, 0);
      chk("tmo_en_cycles", en_hi, 64);
      chk("tmo_err", bus.err_timeout, 1);
      chk("tmo_rv", bus.res_valid, 0);
      chk("tmo_res_kept", bus.res_count, keep);
      // abort coincident with the first valid
      fill(1, 6);
      c_tgt = 4'd2; c_use = 14'h3FFF; c_num = 4;
      do_run(0, 1);
      chk("abort_rv", bus.res_valid, 0);
      chk("abort_err", bus.err_timeout, 0);
      chk("abort_res_kept", bus.res_count, keep);
      fill(0, 6);
      c_tgt = 4'd5; c_use = 14'h2AAA; c_num = 2;
      do_run(0, 0);
      // asynchronous reset during SETUP
      bus.target = 4'd5; bus.use_ro = 14'h3FFF; bus.num_samples = 4'd3;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      @(negedge clock);
      chk("rst_pre_busy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_zero", outs(), '0);
      @(negedge clock);
      rst_n = 1'b1;
      prev_res = '0; prev_rv = 0; prev_err = 0; prev_tgt = '0; prev_use = '0;
      @(negedge clock);
      fill(0, 10);
      c_tgt = 4'd11; c_use = 14'($urandom); c_num = 5;
      do_run(0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
